// File: rtl/switch_conditioner_pkg.sv
// Shared types and constants for the push-switch conditioner: channel indices,
// default channel count and the per-channel auto-repeat state encoding.
package switch_conditioner_pkg;

  localparam int SW_CH     = 0;
  localparam int SW_CE     = 1;
  localparam int SW_CP     = 2;
  localparam int SW_CH_NUM = 3;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2,
    RPT_HOLD   = 2'd3
  } rpt_state_e;

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch bundle between the board pins and the IO controller: raw inputs in,
// debounced level and one-cycle press/release/event pulses out.
interface switch_conditioner_if #(
  parameter int CH_NUM = 3
);
  logic [CH_NUM-1:0] sig_in;
  logic [CH_NUM-1:0] level;
  logic [CH_NUM-1:0] press;
  logic [CH_NUM-1:0] rel;
  logic [CH_NUM-1:0] evt;

  modport master (output sig_in, input level, press, rel, evt);
  modport slave  (input sig_in, output level, press, rel, evt);
endinterface

// File: rtl/switch_conditioner_channel.sv
// One switch channel: 2-flop synchroniser, polarity fix, debounce counter and
// auto-repeat FSM. Every output is a flop; nothing from sig_i reaches an output combinationally.
module switch_channel
  import switch_conditioner_pkg::*;
#(
  parameter int IN_ACTIVE_LOW   = 0,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 5,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic evt_o
);

  localparam logic             PIN_IDLE    = (IN_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  rpt_state_e       state_q, state_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             evt_q;
  logic             rpt_fire;
  logic             sample;

  assign sample = sync_q[1] ^ PIN_IDLE;

  // NOTE: every variable driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    level_d   = level_q;
    db_cnt_d  = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sample != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d   = sample;
        press_d   = sample;
        release_d = ~sample;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = 1'b0;
    unique case (state_q)
      RPT_IDLE: begin
        rpt_cnt_d = '0;
        if (press_d) state_d = (REPEAT_DELAY == 0) ? RPT_HOLD : RPT_DELAY;
      end
      RPT_DELAY: begin
        if (rpt_cnt_q == DELAY_LAST) begin
          rpt_fire  = 1'b1;
          rpt_cnt_d = '0;
          state_d   = RPT_REPEAT;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      RPT_REPEAT: begin
        if (rpt_cnt_q == PERIOD_LAST) begin
          rpt_fire  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      RPT_HOLD: rpt_cnt_d = '0;
      default: begin
        state_d   = RPT_IDLE;
        rpt_cnt_d = '0;
      end
    endcase
    // A release landing on a repeat cycle wins: the repeat pulse is dropped.
    if (release_d) begin
      state_d   = RPT_IDLE;
      rpt_cnt_d = '0;
      rpt_fire  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchroniser rests at the released pin level so reset never looks like a press.
      sync_q    <= {2{PIN_IDLE}};
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      state_q   <= RPT_IDLE;
      rpt_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      evt_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], sig_i};
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      evt_q     <= press_d | rpt_fire;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign evt_o     = evt_q;

endmodule

// File: rtl/switch_conditioner.sv
// Top of the switch conditioner: one independent switch_channel per raw
// switch line, all on the CPU clock.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int CH_NUM          = SW_CH_NUM,
  parameter int IN_ACTIVE_LOW   = 0,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 5,
  parameter int CNT_W           = 16
) (
  input logic                 clk,
  input logic                 rst,
  switch_conditioner_if.slave sw
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    switch_channel #(
      .IN_ACTIVE_LOW  (IN_ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .sig_i    (sw.sig_in[i]),
      .level_o  (sw.level[i]),
      .press_o  (sw.press[i]),
      .release_o(sw.rel[i]),
      .evt_o    (sw.evt[i])
    );
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner: three builds (default, no auto-repeat,
// active-low pins); stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_switch_conditioner;
  import switch_conditioner_pkg::*;

  typedef struct {
    int         cyc;
    logic [2:0] level;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] evt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  switch_conditioner_if #(.CH_NUM(3)) if_a ();
  switch_conditioner_if #(.CH_NUM(3)) if_b ();
  switch_conditioner_if #(.CH_NUM(3)) if_c ();

  switch_conditioner u_a (.clk(clk), .rst(rst), .sw(if_a));
  switch_conditioner #(.REPEAT_DELAY(0)) u_b (.clk(clk), .rst(rst), .sw(if_b));
  switch_conditioner #(.IN_ACTIVE_LOW(1)) u_c (.clk(clk), .rst(rst), .sw(if_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int id, input int c, input logic [2:0] lvl, input logic [2:0] prs,
                      input logic [2:0] rl, input logic [2:0] ev);
    exp_t e;
    e.cyc = c; e.level = lvl; e.press = prs; e.rel = rl; e.evt = ev;
    case (id)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic pop(input int id);
    case (id)
      0: void'(q_a.pop_front());
      1: void'(q_b.pop_front());
      default: void'(q_c.pop_front());
    endcase
  endtask

  task automatic mon(input int id, input logic [2:0] lvl, input logic [2:0] prs,
                     input logic [2:0] rl, input logic [2:0] ev);
    exp_t e;
    bit   have = 0;
    case (id)
      0: if (q_a.size() > 0) begin e = q_a[0]; have = 1; end
      1: if (q_b.size() > 0) begin e = q_b[0]; have = 1; end
      default: if (q_c.size() > 0) begin e = q_c[0]; have = 1; end
    endcase
    if (have && e.cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event dut%0d cyc%0d: got none, required level=%b press=%b rel=%b evt=%b",
               id, e.cyc, e.level, e.press, e.rel, e.evt);
      pop(id);
    end else if ((prs | rl | ev) != 3'b000) begin
      checks++;
      if (!have || e.cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_event dut%0d cyc%0d: got press=%b rel=%b evt=%b, required no pulse",
                 id, cyc, prs, rl, ev);
      end else begin
        pop(id);
        if ({lvl, prs, rl, ev} !== {e.level, e.press, e.rel, e.evt}) begin
          errors++;
          $display("FAIL event dut%0d cyc%0d: got level=%b press=%b rel=%b evt=%b, required level=%b press=%b rel=%b evt=%b",
                   id, cyc, lvl, prs, rl, ev, e.level, e.press, e.rel, e.evt);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if_a.level, if_a.press, if_a.rel, if_a.evt);
    mon(1, if_b.level, if_b.press, if_b.rel, if_b.evt);
    mon(2, if_c.level, if_c.press, if_c.rel, if_c.evt);
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int s;
    if_a.sig_in = 3'b111;
    if_b.sig_in = 3'b111;
    if_c.sig_in = 3'b111;
    rst = 1'b1;
    wait_cyc(3);
    chk("reset_outputs_a", {if_a.level, if_a.press, if_a.rel, if_a.evt}, 12'h000);
    chk("reset_outputs_b", {if_b.level, if_b.press, if_b.rel, if_b.evt}, 12'h000);
    chk("reset_outputs_c", {if_c.level, if_c.press, if_c.rel, if_c.evt}, 12'h000);

    // Switches held through reset become a press once reset drops.
    rst = 1'b0;
    s = cyc;
    push(0, s + 6, 3'b111, 3'b111, 3'b000, 3'b111);
    push(1, s + 6, 3'b111, 3'b111, 3'b000, 3'b111);
    wait_cyc(6);
    if_a.sig_in = 3'b000;
    if_b.sig_in = 3'b000;
    push(0, s + 12, 3'b000, 3'b000, 3'b111, 3'b000);
    push(1, s + 12, 3'b000, 3'b000, 3'b111, 3'b000);
    wait_cyc(12);

    // Clean press on CH held 10 cycles.
    s = cyc;
    if_a.sig_in[SW_CH] = 1'b1;
    push(0, s + 6, 3'b001, 3'b001, 3'b000, 3'b001);
    wait_cyc(10);
    if_a.sig_in[SW_CH] = 1'b0;
    push(0, s + 16, 3'b000, 3'b000, 3'b001, 3'b000);
    wait_cyc(20);

    // Bouncing CE, then stable high from s+4.
    s = cyc;
    for (int i = 0; i < 4; i++) begin
      if_a.sig_in[SW_CE] = ~i[0];
      wait_cyc(1);
    end
    if_a.sig_in[SW_CE] = 1'b1;
    push(0, s + 10, 3'b010, 3'b010, 3'b000, 3'b010);
    wait_cyc(10);
    if_a.sig_in[SW_CE] = 1'b0;
    push(0, s + 20, 3'b000, 3'b000, 3'b010, 3'b000);
    wait_cyc(15);

    // 3-cycle glitch on CE: no activity.
    if_a.sig_in[SW_CE] = 1'b1;
    wait_cyc(3);
    if_a.sig_in[SW_CE] = 1'b0;
    wait_cyc(15);

    // Auto-repeat on CP; release lands on the P+40 repeat slot and suppresses it.
    s = cyc;
    if_a.sig_in[SW_CP] = 1'b1;
    if_b.sig_in[SW_CP] = 1'b1;
    push(0, s + 6, 3'b100, 3'b100, 3'b000, 3'b100);
    for (int k = 0; k < 4; k++) push(0, s + 26 + 5 * k, 3'b100, 3'b000, 3'b000, 3'b100);
    push(1, s + 6, 3'b100, 3'b100, 3'b000, 3'b100);
    wait_cyc(40);
    if_a.sig_in[SW_CP] = 1'b0;
    if_b.sig_in[SW_CP] = 1'b0;
    push(0, s + 46, 3'b000, 3'b000, 3'b100, 3'b000);
    push(1, s + 46, 3'b000, 3'b000, 3'b100, 3'b000);
    wait_cyc(15);

    // Active-low build: CH pressed, CE pressed two cycles later, both released.
    s = cyc;
    if_c.sig_in = 3'b110;
    push(2, s + 6, 3'b001, 3'b001, 3'b000, 3'b001);
    wait_cyc(2);
    if_c.sig_in = 3'b100;
    push(2, s + 8, 3'b011, 3'b010, 3'b000, 3'b010);
    wait_cyc(8);
    if_c.sig_in = 3'b111;
    push(2, s + 16, 3'b000, 3'b000, 3'b011, 3'b000);
    wait_cyc(15);

    // Reset mid-debounce: abandoned without any pulse.
    if_a.sig_in[SW_CH] = 1'b1;
    wait_cyc(3);
    rst = 1'b1;
    if_a.sig_in[SW_CH] = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(15);

    // Reset mid-delay: no repeat and no release pulse afterwards.
    s = cyc;
    if_a.sig_in[SW_CP] = 1'b1;
    push(0, s + 6, 3'b100, 3'b100, 3'b000, 3'b100);
    wait_cyc(10);
    rst = 1'b1;
    if_a.sig_in[SW_CP] = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(30);
    chk("post_reset_level_a", {if_a.level, 9'h000}, 12'h000);

    checks++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left, required 0", q_a.size() + q_b.size() + q_c.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
